// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: port 1 (data) beats port 2 (fetch), one shared registered access bus.
// Define ARB_STARVE_GUARD_EN to let port 2 win after STARVE_MAX consecutive port-1 wins.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        HTRANS_1,
  input  logic [63:0] HADDR_1,
  input  logic        HWRITE_1,
  input  logic [63:0] HWDATA_1,
  input  logic        HTRANS_2,
  input  logic [63:0] HADDR_2,
  input  logic        HWRITE_2,
  input  logic [63:0] HWDATA_2,
  input  logic        HREADY,
  output logic        PSEL,
  output logic [63:0] PADDR,
  output logic        PWRITE,
  output logic [63:0] PDATA,
  output logic        HGRANT_1,
  output logic        HGRANT_2,
  output logic        HDONE_1,
  output logic        HDONE_2,
  output logic        stall_1,
  output logic        stall_2
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("STARVE_MAX must be in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StBusy1, StBusy2} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [63:0] r_paddr;
  logic [63:0] r_pdata;
  logic        r_pwrite;
  logic        w_decide;
  logic        w_pick_1;
  logic        w_pick_2;

  // A new owner is chosen only when the bus is free or the current access completes.
  assign w_decide = (r_state == StIdle) || HREADY;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] r_starve_cnt;
  logic       w_force_2;

  assign w_force_2 = HTRANS_2 && (r_starve_cnt == 4'(STARVE_MAX));
  assign w_pick_1  = HTRANS_1 && !w_force_2;
  assign w_pick_2  = HTRANS_2 && !w_pick_1;

  // Counts port-1 grants taken while port 2 waits; bounded by STARVE_MAX by construction.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_starve_cnt <= 4'd0;
    end else if (w_decide) begin
      if (w_pick_2) begin
        r_starve_cnt <= 4'd0;
      end else if (w_pick_1 && HTRANS_2) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end
`else
  assign w_pick_1 = HTRANS_1;
  assign w_pick_2 = HTRANS_2 && !HTRANS_1;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_decide) begin
      if (w_pick_1) begin
        w_state_next = StBusy1;
      end else if (w_pick_2) begin
        w_state_next = StBusy2;
      end else begin
        w_state_next = StIdle;
      end
    end
  end

  // Access attributes are captured once at grant and held through any wait states.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_paddr  <= 64'd0;
      r_pdata  <= 64'd0;
      r_pwrite <= 1'b0;
    end else if (w_decide) begin
      if (w_pick_1) begin
        r_paddr  <= HADDR_1;
        r_pdata  <= HWDATA_1;
        r_pwrite <= HWRITE_1;
      end else if (w_pick_2) begin
        r_paddr  <= HADDR_2;
        r_pdata  <= HWDATA_2;
        r_pwrite <= HWRITE_2;
      end else begin
        r_pwrite <= 1'b0;
      end
    end
  end

  always_comb begin
    PSEL     = (r_state != StIdle);
    HGRANT_1 = (r_state == StBusy1);
    HGRANT_2 = (r_state == StBusy2);
    HDONE_1  = (r_state == StBusy1) && HREADY && RESET;
    HDONE_2  = (r_state == StBusy2) && HREADY && RESET;
    stall_1  = HTRANS_1 && !HDONE_1;
    stall_2  = HTRANS_2 && !HDONE_2;
    PADDR    = r_paddr;
    PDATA    = r_pdata;
    PWRITE   = r_pwrite;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter: each row is one clock cycle of inputs
// together with the outputs expected during that same cycle.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        HTRANS_1, HWRITE_1, HTRANS_2, HWRITE_2, HREADY;
  logic [63:0] HADDR_1, HWDATA_1, HADDR_2, HWDATA_2;
  logic        PSEL, PWRITE, HGRANT_1, HGRANT_2, HDONE_1, HDONE_2, stall_1, stall_2;
  logic [63:0] PADDR, PDATA;

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .HTRANS_1(HTRANS_1), .HADDR_1(HADDR_1), .HWRITE_1(HWRITE_1), .HWDATA_1(HWDATA_1),
    .HTRANS_2(HTRANS_2), .HADDR_2(HADDR_2), .HWRITE_2(HWRITE_2), .HWDATA_2(HWDATA_2),
    .HREADY(HREADY), .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE), .PDATA(PDATA),
    .HGRANT_1(HGRANT_1), .HGRANT_2(HGRANT_2), .HDONE_1(HDONE_1), .HDONE_2(HDONE_2),
    .stall_1(stall_1), .stall_2(stall_2)
  );

  // ic = {RESET, HTRANS_1, HWRITE_1, HTRANS_2, HWRITE_2, HREADY}
  // ec = {PSEL, PWRITE, HGRANT_1, HGRANT_2, HDONE_1, HDONE_2, stall_1, stall_2}
  typedef struct packed {
    logic [5:0]  ic;
    logic [63:0] a1;
    logic [63:0] d1;
    logic [63:0] a2;
    logic [63:0] d2;
    logic [7:0]  ec;
    logic [63:0] epaddr;
    logic [63:0] epdata;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial begin
    // reset state, then single port-2 read; port 2 still requesting at completion re-wins
    vecs.push_back('{6'b000000, 64'h0, 64'h0, 64'h0, 64'h0, 8'b00000000, 64'h0, 64'h0});
    vecs.push_back('{6'b100101, 64'h0, 64'h0, 64'h1000, 64'h0, 8'b00000001, 64'h0, 64'h0});
    vecs.push_back('{6'b100101, 64'h0, 64'h0, 64'h1000, 64'h0, 8'b10010100, 64'h1000, 64'h0});
    vecs.push_back('{6'b100001, 64'h0, 64'h0, 64'h1000, 64'h0, 8'b10010100, 64'h1000, 64'h0});
    // contention from idle: port-1 write first, then port 2 with no idle bubble
    vecs.push_back('{6'b111101, 64'h2000, 64'hAA, 64'h3000, 64'h55,
                     8'b00000011, 64'h1000, 64'h0});
    vecs.push_back('{6'b100101, 64'h2000, 64'hAA, 64'h3000, 64'h55,
                     8'b11101001, 64'h2000, 64'hAA});
    // port 2 waits one cycle while changing its address; latched access unaffected
    vecs.push_back('{6'b100100, 64'h0, 64'h0, 64'h3008, 64'h66, 8'b10010001, 64'h3000, 64'h55});
    vecs.push_back('{6'b100001, 64'h0, 64'h0, 64'h3008, 64'h66, 8'b10010100, 64'h3000, 64'h55});
    // port-1 read with three wait states; grant from idle ignores HREADY
    vecs.push_back('{6'b110000, 64'h4000, 64'h11, 64'h0, 64'h0, 8'b00000010, 64'h3000, 64'h55});
    vecs.push_back('{6'b110000, 64'h4100, 64'h22, 64'h0, 64'h0, 8'b10100010, 64'h4000, 64'h11});
    vecs.push_back('{6'b110000, 64'h4100, 64'h22, 64'h0, 64'h0, 8'b10100010, 64'h4000, 64'h11});
    vecs.push_back('{6'b110000, 64'h4100, 64'h22, 64'h0, 64'h0, 8'b10100010, 64'h4000, 64'h11});
    vecs.push_back('{6'b100001, 64'h4100, 64'h22, 64'h0, 64'h0, 8'b10101000, 64'h4000, 64'h11});
    // port-1 write, request dropped during the wait, still completes, then idle
    vecs.push_back('{6'b111000, 64'h5000, 64'h77, 64'h0, 64'h0, 8'b00000010, 64'h4000, 64'h11});
    vecs.push_back('{6'b100000, 64'h5000, 64'h77, 64'h0, 64'h0, 8'b11100000, 64'h5000, 64'h77});
    vecs.push_back('{6'b100001, 64'h5000, 64'h77, 64'h0, 64'h0, 8'b11101000, 64'h5000, 64'h77});
    vecs.push_back('{6'b100001, 64'h0, 64'h0, 64'h0, 64'h0, 8'b00000000, 64'h5000, 64'h77});
    // port-2 write aborted by reset during a wait; no done pulse, fresh grant afterwards
    vecs.push_back('{6'b100110, 64'h0, 64'h0, 64'h6000, 64'h99, 8'b00000001, 64'h5000, 64'h77});
    vecs.push_back('{6'b100110, 64'h0, 64'h0, 64'h6000, 64'h99, 8'b11010001, 64'h6000, 64'h99});
    vecs.push_back('{6'b000111, 64'h0, 64'h0, 64'h6000, 64'h99, 8'b11010001, 64'h6000, 64'h99});
    vecs.push_back('{6'b100111, 64'h0, 64'h0, 64'h6000, 64'h99, 8'b00000001, 64'h0, 64'h0});
    vecs.push_back('{6'b100001, 64'h0, 64'h0, 64'h6000, 64'h99, 8'b11010100, 64'h6000, 64'h99});
    vecs.push_back('{6'b100001, 64'h0, 64'h0, 64'h0, 64'h0, 8'b00000000, 64'h6000, 64'h99});
    // both ports held requesting: port 1 wins four times; fifth decision depends on the guard
    vecs.push_back('{6'b110101, 64'h7000, 64'h0, 64'h8000, 64'h0, 8'b00000011, 64'h6000, 64'h99});
    for (int i = 0; i < 4; i++) begin
      vecs.push_back('{6'b110101, 64'h7000, 64'h0, 64'h8000, 64'h0,
                       8'b10101001, 64'h7000, 64'h0});
    end
`ifdef ARB_STARVE_GUARD_EN
    vecs.push_back('{6'b110101, 64'h7000, 64'h0, 64'h8000, 64'h0, 8'b10010110, 64'h8000, 64'h0});
`else
    vecs.push_back('{6'b110101, 64'h7000, 64'h0, 64'h8000, 64'h0, 8'b10101001, 64'h7000, 64'h0});
`endif
    vecs.push_back('{6'b100001, 64'h7000, 64'h0, 64'h8000, 64'h0, 8'b10101000, 64'h7000, 64'h0});
    vecs.push_back('{6'b100001, 64'h0, 64'h0, 64'h0, 64'h0, 8'b00000000, 64'h7000, 64'h0});

    {RESET, HTRANS_1, HWRITE_1, HTRANS_2, HWRITE_2, HREADY} = 6'b0;
    {HADDR_1, HWDATA_1, HADDR_2, HWDATA_2} = '0;
    repeat (2) @(posedge CLK);

    // reset state
    @(negedge CLK);
    #1;
    n_checks++;
    if ({PSEL, PWRITE, HGRANT_1, HGRANT_2, HDONE_1, HDONE_2, stall_1, stall_2, PADDR, PDATA}
        !== {8'b0, 64'h0, 64'h0}) begin
      n_fail++;
      $display("FAIL reset state: psel=%b pwrite=%b g1=%b g2=%b d1=%b d2=%b paddr=%h pdata=%h",
               PSEL, PWRITE, HGRANT_1, HGRANT_2, HDONE_1, HDONE_2, PADDR, PDATA);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      logic [7:0] act;
      @(negedge CLK);
      {RESET, HTRANS_1, HWRITE_1, HTRANS_2, HWRITE_2, HREADY} = vecs[i].ic;
      HADDR_1  = vecs[i].a1;
      HWDATA_1 = vecs[i].d1;
      HADDR_2  = vecs[i].a2;
      HWDATA_2 = vecs[i].d2;
      #1;
      act = {PSEL, PWRITE, HGRANT_1, HGRANT_2, HDONE_1, HDONE_2, stall_1, stall_2};
      n_checks++;
      if ({act, PADDR, PDATA} !== {vecs[i].ec, vecs[i].epaddr, vecs[i].epdata}) begin
        n_fail++;
        $display("FAIL row %0d: got ctl=%b paddr=%h pdata=%h, want ctl=%b paddr=%h pdata=%h",
                 i, act, PADDR, PDATA, vecs[i].ec, vecs[i].epaddr, vecs[i].epdata);
      end
      // expired wait: fourth cycle of the port-1 access completes
      if (i == 12) begin
        n_checks++;
        if ({HDONE_1, stall_1, PADDR} !== {1'b1, 1'b0, 64'h4000}) begin
          n_fail++;
          $display("FAIL expired wait: done_1=%b stall_1=%b paddr=%h", HDONE_1, stall_1, PADDR);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_MAX, 4, consecutive port-1 wins over a waiting port 2 before port 2 is forced (1..15).
REQ-002 SHALL have ports, clock and reset first:
- CLK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset.
- HTRANS_1  in  1  port-1 (data) request; held until HDONE_1.
- HADDR_1  in  64  port-1 address.
- HWRITE_1  in  1  port-1 write (1) / read (0).
- HWDATA_1  in  64  port-1 write data.
- HTRANS_2  in  1  port-2 (fetch) request; held until HDONE_2.
- HADDR_2  in  64  port-2 address.
- HWRITE_2  in  1  port-2 write / read.
- HWDATA_2  in  64  port-2 write data.
- HREADY  in  1  memory completes the current access this cycle.
- PSEL  out  1  access in progress on shared bus.
- PADDR  out  64  shared address (registered).
- PWRITE  out  1  shared write strobe (registered).
- PDATA  out  64  shared write data (registered).
- HGRANT_1 / HGRANT_2  out  1 each  owner of the current access (registered, one-hot or zero).
- HDONE_1 / HDONE_2  out  1 each  one-cycle completion pulse; memory read data valid this cycle.
- stall_1 / stall_2  out  1 each  requester must hold its pipeline stage.

Function
REQ-003 SHALL implement FSM states IDLE, BUSY_1, BUSY_2.
REQ-004 SHALL arbitrate only at decision points: state IDLE, or BUSY_x with HREADY=1.
REQ-005 At a decision point with requests, SHALL enter BUSY_1 or BUSY_2 next cycle, latching owner's HADDR/HWRITE/HWDATA into PADDR/PWRITE/PDATA and setting HGRANT_x, PSEL=1.
REQ-006 At a decision point with no request, SHALL enter IDLE next cycle with PSEL=0, both HGRANT=0, PWRITE=0; PADDR/PDATA hold.
REQ-007 Default priority: port 1 wins when both request.
REQ-008 Access latency: request seen in IDLE at cycle N -> PSEL=1 at N+1; zero wait states -> HDONE at N+1.
REQ-009 HDONE_x SHALL be combinational: state==BUSY_x AND HREADY AND RESET; HDONE_1 and HDONE_2 never both high.
REQ-010 Back-to-back: completion cycle with pending request SHALL go directly to next BUSY state, no IDLE bubble.
REQ-011 PADDR/PWRITE/PDATA SHALL remain stable while BUSY_x and HREADY=0 (wait states unbounded).
REQ-012 stall_x = HTRANS_x AND NOT HDONE_x.
REQ-013 Requester dropping HTRANS_x mid-access: latched access SHALL still complete and pulse HDONE_x; not re-granted unless re-requested.
REQ-014 Requester changing address mid-access SHALL not affect the latched access.
REQ-015 The completing owner still requesting at its own completion is a new request, arbitrated normally.

Reset
REQ-016 RESET=0 at a rising edge SHALL force: state IDLE, PSEL=0, PWRITE=0, PADDR=0, PDATA=0, HGRANT_1/2=0, starvation counter=0.
REQ-017 Reset mid-access SHALL abort it; no HDONE pulse while RESET=0; stall_x follows HTRANS_x.
REQ-018 First grant possible at the first decision point after RESET returns high.

Configuration
REQ-019 Macro ARB_STARVE_GUARD_EN defined: 4-bit counter increments whenever port 1 is granted while HTRANS_2=1; when counter==STARVE_MAX at a decision point with HTRANS_2=1, port 2 SHALL win; counter clears on any port-2 grant.
REQ-020 Macro undefined: no counter; strict port-1 priority; port 2 may starve indefinitely.

Verification
REQ-021 Single read: reset, HTRANS_2=1, HADDR_2=0x1000, HREADY=1 -> next cycle PSEL=1, PADDR=0x1000, HGRANT_2=1, HDONE_2=1; stall_2 low that cycle.
REQ-022 Contention: both request from IDLE, HADDR_1=0x2000 write HWDATA_1=0xAA -> BUSY_1 with PDATA=0xAA, PWRITE=1, then BUSY_2 with no IDLE between.
REQ-023 Wait states: BUSY_1, HREADY low 3 cycles -> PADDR stable, stall_1=1, HDONE_1 only in 4th cycle.
REQ-024 Starvation (ARB_STARVE_GUARD_EN, STARVE_MAX=4): both held requesting -> 4 port-1 accesses then one port-2; without macro, port 2 never granted.
REQ-025 Reset mid-access: BUSY_2 with HREADY=0, assert RESET=0 one cycle -> PSEL=0, HGRANT_2=0, no HDONE_2 pulse; fresh grant after release.
REQ-026 Request drop: HTRANS_1 deasserted during BUSY_1 wait -> HDONE_1 still pulses on HREADY, then IDLE.
